// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM slot arbiter.
//   state_t    : sequencer states
//   port_req_t : one client's access request (we/addr/din)
package sdram_arb_pkg;
  localparam int NUM_PORTS            = 2;
  localparam int ADDR_W               = 25;
  localparam int DATA_W               = 8;
  localparam int SLOT_LEN_DEF         = 12;
  localparam int CE_HIGH_DEF          = 4;
  localparam int DATA_CYCLE_DEF       = 9;
  localparam int REFRESH_INTERVAL_DEF = 480;
  localparam int INIT_WAIT_DEF        = 320;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, REFRESH} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } port_req_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// Client-side bundle for the arbiter: port 0 (video/DMA) and port 1 (CPU).
//   master : client view (drives req/we/addr/din, receives ack/dout)
//   slave  : arbiter view
interface sdram_arbiter_if;
  import sdram_arb_pkg::*;
  logic              p0_req, p0_we, p0_ack;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_din, p0_dout;
  logic              p1_req, p1_we, p1_ack;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_din, p1_dout;

  modport master (output p0_req, p0_we, p0_addr, p0_din, p1_req, p1_we, p1_addr, p1_din,
                  input  p0_ack, p0_dout, p1_ack, p1_dout);
  modport slave  (input  p0_req, p0_we, p0_addr, p0_din, p1_req, p1_we, p1_addr, p1_din,
                  output p0_ack, p0_dout, p1_ack, p1_dout);
endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
//   clk, reset_n : clock, async active-low reset
//   en           : count enable (low while SDRAM init is in progress)
//   clr          : refresh slot has started, drop the pending flag
//   pending      : a refresh slot is owed
module sdram_refresh_timer #(
  parameter int INTERVAL = 480
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic pending
);
  localparam int CW = $clog2(INTERVAL);
  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(INTERVAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap)    cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
      // A fresh expiry wins over a clear so it is never lost; repeated
      // expiries collapse into one owed refresh.
      if (wrap)     pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter / slot sequencer in front of the 8-bit SDRAM controller.
//   clk, reset_n   : clock shared with the controller, async active-low reset
//   cl             : client handshakes (level req, one-cycle ack, per-port dout)
//   sd_init        : controller init, high for 4 clocks after reset release
//   sd_ce/sd_we/sd_addr/sd_din/sd_refresh : controller slot signals
//   sd_dout        : controller read data
//   busy           : high during init and while a slot is running
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int SLOT_LEN         = SLOT_LEN_DEF,
  parameter int CE_HIGH          = CE_HIGH_DEF,
  parameter int DATA_CYCLE       = DATA_CYCLE_DEF,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int INIT_WAIT        = INIT_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  sdram_arbiter_if.slave    cl,
  output logic              sd_init,
  output logic              sd_ce,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  output logic              sd_refresh,
  input  logic [DATA_W-1:0] sd_dout,
  output logic              busy
);
  localparam int SW = $clog2(SLOT_LEN);
  localparam int IW = $clog2(INIT_WAIT + 4);

  state_t                              state;
  logic [SW-1:0]                       slot_cnt;
  logic [IW-1:0]                       init_cnt;
  logic                                rr_last, gnt, win, ref_pending;
  logic [NUM_PORTS-1:0]                req, ack;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    dout;
  port_req_t [NUM_PORTS-1:0]           preq;

  assign req     = {cl.p1_req, cl.p0_req};
  assign preq[0] = {cl.p0_we, cl.p0_addr, cl.p0_din};
  assign preq[1] = {cl.p1_we, cl.p1_addr, cl.p1_din};
  assign cl.p0_ack  = ack[0];
  assign cl.p1_ack  = ack[1];
  assign cl.p0_dout = dout[0];
  assign cl.p1_dout = dout[1];

  // Tie goes to the port that did not win last time.
  always_comb begin
    win = 1'b0;
    if (&req)        win = ~rr_last;
    else if (req[1]) win = 1'b1;
  end

  sdram_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_rtmr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state != INIT),
    .clr     ((state == REFRESH) && (slot_cnt == '0)),
    .pending (ref_pending)
  );

  // slot_cnt == c during slot cycle c; every output is set one edge ahead
  // so that it is valid in the cycle it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      slot_cnt   <= '0;
      init_cnt   <= '0;
      rr_last    <= 1'b1;
      gnt        <= 1'b0;
      sd_init    <= 1'b1;
      busy       <= 1'b1;
      sd_ce      <= 1'b0;
      sd_we      <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_refresh <= 1'b0;
      ack        <= '0;
      dout       <= '0;
    end else begin
      ack <= '0;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          sd_init  <= (init_cnt < IW'(3));
          if (init_cnt == IW'(INIT_WAIT + 3)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          slot_cnt <= '0;
          if (ref_pending) begin
            state      <= REFRESH;
            sd_refresh <= 1'b1;
            busy       <= 1'b1;
          end else if (|req) begin
            state   <= ACCESS;
            gnt     <= win;
            sd_we   <= preq[win].we;
            sd_addr <= preq[win].addr;
            sd_din  <= preq[win].din;
            sd_ce   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACCESS: begin
          slot_cnt <= slot_cnt + 1'b1;
          sd_ce    <= (slot_cnt < SW'(CE_HIGH - 1));
          if (slot_cnt == SW'(DATA_CYCLE) && !sd_we) dout[gnt] <= sd_dout;
          if (slot_cnt == SW'(SLOT_LEN - 2)) begin
            ack[gnt] <= 1'b1;
            rr_last  <= gnt;
          end
          if (slot_cnt == SW'(SLOT_LEN - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        REFRESH: begin
          slot_cnt   <= slot_cnt + 1'b1;
          sd_refresh <= (slot_cnt < SW'(CE_HIGH - 1));
          if (slot_cnt == SW'(SLOT_LEN - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init timing, a table of single-port
// transactions, round-robin + refresh insertion, and reset mid-slot.
module tb_sdram_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        sd_init, sd_ce, sd_we, sd_refresh, busy;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic [7:0]  sd_dout = 8'h00;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if bus();

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .cl(bus),
    .sd_init(sd_init), .sd_ce(sd_ce), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_refresh(sd_refresh), .sd_dout(sd_dout), .busy(busy)
  );

  // Controller stand-in: writes land while ce is high, unwritten bytes read
  // back as addr[7:0]^5A.
  logic [7:0] mem [logic [24:0]];
  always @(negedge clk) begin
    if (sd_ce && sd_we) mem[sd_addr] = sd_din;
    sd_dout = mem.exists(sd_addr) ? mem[sd_addr] : (sd_addr[7:0] ^ 8'h5A);
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [24:0] a, input logic [7:0] d);
    if (!p) begin bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_din = d; end
    else    begin bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_din = d; end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    int c; bit started, bad, got; logic [7:0] dv;
    started = 0; bad = 0; got = 0; c = -1; dv = 8'h00;
    drive(v.port, 1, v.we, v.addr, v.din);
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (!started && sd_ce) begin started = 1; c = 0; end
      else if (started) c++;
      if (started && (sd_addr !== v.addr || sd_we !== v.we || (v.we && sd_din !== v.din))) bad = 1;
      if (v.port ? bus.p1_ack : bus.p0_ack) begin
        got = 1;
        dv  = v.port ? bus.p1_dout : bus.p0_dout;
      end
    end
    drive(v.port, 0, 0, 25'h0, 8'h00);
    chk($sformatf("v%0d ack_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d ack_slot_cycle", idx), 32'(c), 32'd11);
    chk($sformatf("v%0d slot_stable", idx), 32'(bad), 32'd0);
    chk($sformatf("v%0d dout", idx), 32'(dv), 32'(v.exp_dout));
    @(negedge clk);
    chk($sformatf("v%0d ack_one_cycle", idx), 32'(v.port ? bus.p1_ack : bus.p0_ack), 32'd0);
    chk($sformatf("v%0d busy_idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    int init_hi, first_ce, ack_k, cnt_ack, cnt_ce, r2, lb, la, last_rise;
    int ref_hi, ovl, ce_in_ref;
    bit found, prev_ref;
    logic [24:0] ce_addr;
    logic [7:0]  dv;
    int ack_cyc[$]; bit ack_prt[$]; int ref_rise[$];

    vecs[0] = '{0, 1, 25'h1000000, 8'hA5, 8'h00};
    vecs[1] = '{0, 0, 25'h1000000, 8'h00, 8'hA5};
    vecs[2] = '{1, 1, 25'h0ABCDEF, 8'h3C, 8'h79};
    vecs[3] = '{1, 0, 25'h0ABCDEF, 8'h00, 8'h3C};
    vecs[4] = '{0, 1, 25'h0000000, 8'hFF, 8'hA5};
    vecs[5] = '{0, 0, 25'h0000000, 8'h00, 8'hFF};
    vecs[6] = '{0, 0, 25'h0000042, 8'h00, 8'h18};
    vecs[7] = '{1, 0, 25'h1FFFFFF, 8'h00, 8'hA5};

    drive(0, 0, 0, 25'h0, 8'h00);
    drive(1, 0, 0, 25'h0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst sd_init", 32'(sd_init), 32'd1);
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst sd_ce", 32'(sd_ce), 32'd0);
    chk("rst sd_refresh", 32'(sd_refresh), 32'd0);
    chk("rst sd_addr", 32'(sd_addr), 32'd0);
    chk("rst acks", 32'({bus.p0_ack, bus.p1_ack}), 32'd0);
    chk("rst douts", 32'({bus.p0_dout, bus.p1_dout}), 32'd0);

    // p1 read requested during init
    drive(1, 1, 0, 25'h0000123, 8'h00);
    reset_n = 1'b1;
    init_hi = 0; first_ce = -1; ack_k = -1; ce_addr = '0; dv = 8'h00;
    for (int k = 0; k < 400 && ack_k < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (sd_init) init_hi++;
      if (sd_ce && first_ce < 0) begin first_ce = k; ce_addr = sd_addr; end
      if (bus.p1_ack) begin ack_k = k; dv = bus.p1_dout; end
    end
    drive(1, 0, 0, 25'h0, 8'h00);
    chk("init sd_init_clocks", 32'(init_hi), 32'd4);
    chk("init first_ce_cycle", 32'(first_ce), 32'd325);
    chk("init sd_addr", 32'(ce_addr), 32'h123);
    chk("init ack_cycle", 32'(ack_k), 32'd336);
    chk("init p1_dout", 32'(dv), 32'h79);

    foreach (vecs[i]) do_txn(i, vecs[i]);

    // Sync on a refresh slot, then hold both ports requesting.
    found = 0;
    for (int k = 0; k < 1200 && !found; k++) begin
      @(negedge clk);
      if (sd_refresh) found = 1;
    end
    chk("rr refresh_sync", 32'(found), 32'd1);
    drive(0, 1, 0, 25'h0000010, 8'h00);
    drive(1, 1, 0, 25'h0000020, 8'h00);
    ref_hi = 0; ovl = 0; ce_in_ref = 0; prev_ref = 0; last_rise = -100;
    for (int k = 0; k < 560; k++) begin
      if (k > 0) @(negedge clk);
      if (sd_refresh && !prev_ref) begin ref_rise.push_back(k); last_rise = k; end
      prev_ref = sd_refresh;
      if (sd_refresh) ref_hi++;
      if (sd_ce && sd_refresh) ovl++;
      if (sd_ce && (k - last_rise) < 12) ce_in_ref++;
      if (bus.p0_ack) begin
        ack_cyc.push_back(k); ack_prt.push_back(0);
        chk("rr p0_dout", 32'(bus.p0_dout), 32'h4A);
      end
      if (bus.p1_ack) begin
        ack_cyc.push_back(k); ack_prt.push_back(1);
        chk("rr p1_dout", 32'(bus.p1_dout), 32'h7A);
      end
    end
    chk("rr ack_count_ge4", 32'(ack_cyc.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      chk($sformatf("rr ack%0d_port", i), 32'(ack_prt[i]), 32'(i % 2));
      chk($sformatf("rr ack%0d_cycle", i), 32'(ack_cyc[i]), 32'(24 + 13 * i));
    end
    chk("ref rises", 32'(ref_rise.size()), 32'd2);
    chk("ref high_clocks", 32'(ref_hi), 32'd8);
    chk("ref ce_overlap", 32'(ovl), 32'd0);
    chk("ref ce_in_slot", 32'(ce_in_ref), 32'd0);
    r2 = (ref_rise.size() >= 2) ? ref_rise[1] : -1;
    chk("ref interval", 32'(r2 >= 480 && r2 <= 494), 32'd1);
    lb = -1; la = -1;
    foreach (ack_cyc[i]) begin
      if (ack_cyc[i] < r2) lb = i;
      else if (la < 0) la = i;
    end
    chk("ref acks_around", 32'(lb >= 0 && la >= 0), 32'd1);
    if (lb >= 0 && la >= 0) begin
      chk("ref gap_before", 32'(r2 - ack_cyc[lb]), 32'd2);
      chk("ref gap_after", 32'(ack_cyc[la] - r2), 32'd24);
      chk("ref rr_continues", 32'(ack_prt[lb] != ack_prt[la]), 32'd1);
    end
    // Release each port on its own ack.
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (bus.p0_ack) bus.p0_req = 0;
      if (bus.p1_ack) bus.p1_req = 0;
      if (!bus.p0_req && !bus.p1_req) found = 1;
    end
    chk("rr drained", 32'(found), 32'd1);

    // Reset at slot cycle 5 of a p0 read.
    drive(0, 1, 0, 25'h0000055, 8'h00);
    found = 0;
    for (int k = 0; k < 1200 && !found; k++) begin
      @(negedge clk);
      if (sd_ce) found = 1;
    end
    chk("mid ce_seen", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid sd_ce", 32'(sd_ce), 32'd0);
    chk("mid sd_refresh", 32'(sd_refresh), 32'd0);
    chk("mid p0_ack", 32'(bus.p0_ack), 32'd0);
    chk("mid sd_init", 32'(sd_init), 32'd1);
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid p0_dout", 32'(bus.p0_dout), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt_ack = 0; init_hi = 0; cnt_ce = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.p0_ack) cnt_ack++;
      if (sd_init) init_hi++;
      if (sd_ce) cnt_ce++;
    end
    drive(0, 0, 0, 25'h0, 8'h00);
    chk("mid no_ack", 32'(cnt_ack), 32'd0);
    chk("mid reinit_clocks", 32'(init_hi), 32'd4);
    chk("mid no_ce_in_init", 32'(cnt_ce), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-port request arbiter and slot sequencer sitting directly upstream of the single-port 8-bit SDRAM controller. It converts level req/ack client handshakes (video/DMA port 0, CPU port 1) into the controller's edge-triggered ce/we/addr/din slots. It inserts periodic auto-refresh slots and holds off all traffic until SDRAM initialisation has completed. Read data is captured at a fixed slot cycle and returned per port.

Parameters:
SLOT_LEN, 12, clocks per access/refresh slot; must be >= 10
CE_HIGH, 4, clocks sd_ce/sd_refresh held high at slot start; must be >= 2 and <= SLOT_LEN-4
DATA_CYCLE, 9, slot cycle at which sd_dout is captured; must be >= 9 and < SLOT_LEN
REFRESH_INTERVAL, 480, clocks between refresh requests
INIT_WAIT, 320, clocks after sd_init deasserts before the first grant

Ports:
clk  in  1  system clock, same clock as the SDRAM controller
reset_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 (video) request, level; held until p0_ack
p0_we  in  1  port 0 write enable
p0_addr  in  25  port 0 byte address
p0_din  in  8  port 0 write data
p0_ack  out  1  one-cycle completion pulse
p0_dout  out  8  port 0 read data
p1_req, p1_we, p1_addr, p1_din, p1_ack, p1_dout  same as port 0, for the CPU
sd_init  out  1  to controller init
sd_ce  out  1  to controller ce
sd_we  out  1  to controller we
sd_addr  out  25  to controller addr
sd_din  out  8  to controller din
sd_refresh  out  1  to controller refresh
sd_dout  in  8  from controller dout
busy  out  1  high while any slot is in progress or init is not complete

Behaviour:
- Reset (async, reset_n=0):
  - sd_init=1, busy=1; all other outputs 0.
  - State=INIT, slot counter=0, refresh counter=0, refresh_pending=0, rr_last=1 (port 0 wins first tie).
- States: INIT -> IDLE -> ACCESS | REFRESH -> IDLE.
- INIT:
  - sd_init=1 for the first 4 clocks after reset release, then 0.
  - Wait INIT_WAIT further clocks, then go to IDLE.
  - Requests arriving during INIT are held pending, never dropped.
- IDLE: 1 clock minimum. Selection priority:
  - refresh_pending first, then round-robin between p0_req and p1_req.
  - On a tie, grant the port not granted last (rr_last).
  - If nothing is pending, stay in IDLE with busy=0.
- ACCESS (slot cycles 0..SLOT_LEN-1, all outputs registered):
  - On grant, latch the winner's addr/we/din into sd_addr/sd_we/sd_din.
  - These stay stable for the whole slot: the controller samples addr on slot cycle 2 and we/din on slot cycle 4.
  - sd_ce=1 for cycles 0..CE_HIGH-1, 0 for the remainder of the slot.
  - Read: at cycle DATA_CYCLE, copy sd_dout into the granted port's dout register.
  - Write: dout is not modified.
  - At cycle SLOT_LEN-1, pulse that port's ack for one clock and update rr_last; next state IDLE.
- REFRESH:
  - sd_refresh=1 for cycles 0..CE_HIGH-1; sd_ce stays 0.
  - Clear refresh_pending at cycle 0; no ack; after SLOT_LEN cycles, go to IDLE.
- Refresh timer:
  - Free-running counter, active once INIT is exited.
  - On reaching REFRESH_INTERVAL-1, set refresh_pending and wrap to 0.
  - If refresh_pending is already set at that point, it stays set; no count of multiple refreshes is kept.
- sd_ce and sd_refresh are never high in the same cycle. Each has at least SLOT_LEN-CE_HIGH+1 low clocks between rising edges.
- A req dropped before ack is a protocol violation. The slot still completes and ack still pulses.
- pN_dout holds its value until the next read completion on that port.
- Reset mid-slot: outputs drop immediately; the sequence restarts from INIT, including a new sd_init pulse.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {INIT, IDLE, ACCESS, REFRESH}
  - SLOT_LEN/CE_HIGH/DATA_CYCLE defaults
  - a port-request struct {we, addr[24:0], din[7:0]}
- Sub-module sdram_refresh_timer: counter plus refresh_pending flag, with a clear input driven at REFRESH slot cycle 0.

Test Plan:
- Reset release, p1 read of 0x0000123 asserted immediately -> sd_init high 4 clocks; no sd_ce before INIT_WAIT+4 clocks; then one slot with sd_addr=0x0000123; p1_ack at slot cycle 11 with p1_dout equal to the model byte.
- p0 write 0x1000000/0xA5, then p0 read of the same address -> sd_we=1 and sd_din=0xA5 stable cycles 0..11; the read returns p0_dout=0xA5 (bt byte select via addr[24]).
- p0_req and p1_req held continuously -> grants alternate p0,p1,p0,p1; each ack is spaced exactly SLOT_LEN+1 clocks apart.
- Refresh timer expires mid-ACCESS with both ports requesting -> the current slot completes, the next slot is REFRESH (sd_refresh high 4 clocks, sd_ce low), then port arbitration resumes.
- reset_n pulsed low at slot cycle 5 of a read -> sd_ce, sd_refresh and ack are 0 immediately; no ack is issued; INIT restarts with sd_init=1.
